// File: rtl/keccak_f400_perm.sv
// Keccak-f[400] engine on port B of the shared state memory: it captures the
// state on a start request, runs 20 rounds (one per clock) and writes back the
// result with a done flag, retrying the write-back if port A overwrote it.
module keccak_f400_perm (
   input  logic         i_common_clk,
   input  logic         i_common_rstn,
   input  logic [399:0] i_v_state,
   input  logic [7:0]   i_v_ctrl_reg,
   output logic         o_b_wr,
   output logic [399:0] o_v_state,
   output logic [7:0]   o_v_ctrl_reg
);

   typedef enum logic [2:0] {IDLE, ACK, RUN, WB, CHK} fsm_t;

   fsm_t          fsm_reg, fsm_next;
   logic [399:0]  state_reg, state_next;
   logic [4:0]    round_reg, round_next;
   logic          b_wr_reg;
   logic [7:0]    ctrl_reg;
   logic [15:0]   rc;
   logic [399:0]  round_out;

   logic [4:0][15:0]  col;
   logic [4:0][15:0]  d_col;
   logic [24:0][15:0] pi_lane;
   logic [24:0][15:0] chi_lane;

   function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
      logic [31:0] d;
      d = {v, v} << n;
      return d[31:16];
   endfunction

   // Standard Keccak rho offsets reduced mod 16, indexed by lane x+5y.
   function automatic int rho_off(input int k);
      case (k)
         0: return 0;   1: return 1;   2: return 14;  3: return 12;  4: return 11;
         5: return 4;   6: return 12;  7: return 6;   8: return 7;   9: return 4;
         10: return 3;  11: return 10; 12: return 11; 13: return 9;  14: return 7;
         15: return 9;  16: return 13; 17: return 15; 18: return 5;  19: return 8;
         20: return 2;  21: return 2;  22: return 13; 23: return 8;  24: return 14;
         default: return 0;
      endcase
   endfunction

   always_comb begin
      case (round_reg)
         5'd0:  rc = 16'h0001;  5'd1:  rc = 16'h8082;  5'd2:  rc = 16'h808A;
         5'd3:  rc = 16'h8000;  5'd4:  rc = 16'h808B;  5'd5:  rc = 16'h0001;
         5'd6:  rc = 16'h8081;  5'd7:  rc = 16'h8009;  5'd8:  rc = 16'h008A;
         5'd9:  rc = 16'h0088;  5'd10: rc = 16'h8009;  5'd11: rc = 16'h000A;
         5'd12: rc = 16'h808B;  5'd13: rc = 16'h008B;  5'd14: rc = 16'h8089;
         5'd15: rc = 16'h8003;  5'd16: rc = 16'h8002;  5'd17: rc = 16'h0080;
         5'd18: rc = 16'h800A;  5'd19: rc = 16'h000A;
         default: rc = 16'h0000;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_theta
         assign col[gi] = state_reg[16*gi +: 16] ^ state_reg[16*(gi+5) +: 16]
                        ^ state_reg[16*(gi+10) +: 16] ^ state_reg[16*(gi+15) +: 16]
                        ^ state_reg[16*(gi+20) +: 16];
         assign d_col[gi] = col[(gi+4)%5] ^ rol16(col[(gi+1)%5], 1);
      end

      // Lane (x,y) lands at (y, 2x+3y) after pi; theta and rho fold in here.
      for (gi = 0; gi < 25; gi++) begin : g_rho_pi
         localparam int X   = gi % 5;
         localparam int Y   = gi / 5;
         localparam int DST = Y + 5*((2*X + 3*Y) % 5);
         assign pi_lane[DST] = rol16(state_reg[16*gi +: 16] ^ d_col[X], rho_off(gi));
      end

      for (gi = 0; gi < 25; gi++) begin : g_chi_iota
         localparam int X = gi % 5;
         localparam int Y = gi / 5;
         assign chi_lane[gi] = pi_lane[gi]
                             ^ (~pi_lane[5*Y + (X+1)%5] & pi_lane[5*Y + (X+2)%5]);
         if (gi == 0) begin : g_iota
            assign round_out[15:0] = chi_lane[0] ^ rc;
         end else begin : g_pass
            assign round_out[16*gi +: 16] = chi_lane[gi];
         end
      end
   endgenerate

   always_comb begin
      fsm_next   = fsm_reg;
      state_next = state_reg;
      round_next = round_reg;
      case (fsm_reg)
         IDLE: begin
            if (i_v_ctrl_reg[1:0] == 2'b01) begin
               state_next = i_v_state;
               fsm_next   = ACK;
            end
         end
         ACK: begin
            round_next = 5'd0;
            fsm_next   = RUN;
         end
         RUN: begin
            state_next = round_out;
            round_next = round_reg + 5'd1;
            if (round_reg == 5'd19) fsm_next = WB;
         end
         WB:  fsm_next = CHK;
         // A port-A write in the WB cycle wins; retry until done sticks.
         CHK: fsm_next = (i_v_ctrl_reg == 8'h04) ? IDLE : WB;
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge i_common_clk) begin
      if (!i_common_rstn) begin
         fsm_reg   <= IDLE;
         state_reg <= '0;
         round_reg <= '0;
         b_wr_reg  <= 1'b0;
         ctrl_reg  <= 8'h00;
      end else begin
         fsm_reg   <= fsm_next;
         state_reg <= state_next;
         round_reg <= round_next;
         b_wr_reg  <= (fsm_next == ACK) || (fsm_next == WB);
         if (fsm_next == ACK)
            ctrl_reg <= 8'h02;
         else if (fsm_next == WB)
            ctrl_reg <= 8'h04;
      end
   end

   assign o_b_wr       = b_wr_reg;
   assign o_v_state    = state_reg;
   assign o_v_ctrl_reg = ctrl_reg;

endmodule

// File: tb/tb_keccak_f400_perm.sv
// Bench for keccak_f400_perm: models the shared memory (port A wins), checks
// every port-B write against a lane-array Keccak-f[400] model.
module tb_keccak_f400_perm;

   localparam logic [15:0] RC_TAB [20] = '{
      16'h0001, 16'h8082, 16'h808A, 16'h8000, 16'h808B, 16'h0001, 16'h8081,
      16'h8009, 16'h008A, 16'h0088, 16'h8009, 16'h000A, 16'h808B, 16'h008B,
      16'h8089, 16'h8003, 16'h8002, 16'h0080, 16'h800A, 16'h000A};

   logic          clk = 1'b0;
   logic          rstn;
   logic [399:0]  mem_state = '0;
   logic [7:0]    mem_ctrl  = 8'h00;
   logic          b_wr;
   logic [399:0]  b_state;
   logic [7:0]    b_ctrl;
   logic          a_state_wr, a_ctrl_wr;
   logic [399:0]  a_state;
   logic [7:0]    a_ctrl;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   bit            mon_on = 1'b0;
   logic [7:0]    exp_ctrl [int];
   logic [399:0]  exp_data [int];

   always #5 clk = ~clk;

   keccak_f400_perm dut (
      .i_common_clk  (clk),
      .i_common_rstn (rstn),
      .i_v_state     (mem_state),
      .i_v_ctrl_reg  (mem_ctrl),
      .o_b_wr        (b_wr),
      .o_v_state     (b_state),
      .o_v_ctrl_reg  (b_ctrl)
   );

   // Shared memory: port-A writes land after port-B writes, so A wins.
   always @(posedge clk) begin
      if (b_wr) begin
         mem_state <= b_state;
         mem_ctrl  <= b_ctrl;
      end
      if (a_state_wr) mem_state <= a_state;
      if (a_ctrl_wr)  mem_ctrl  <= a_ctrl;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [399:0] act, input logic [399:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
      end
   endtask

   function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
      if (n == 0) return v;
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic logic [399:0] model_round(input logic [399:0] s, input int r);
      logic [15:0] a [5][5];
      logic [15:0] b [5][5];
      logic [15:0] c [5];
      logic [15:0] d [5];
      int          rho [5][5];
      int          px, py, nx;
      logic [399:0] o;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            a[x][y] = s[16*(x+5*y) +: 16];
      rho[0][0] = 0;
      px = 1; py = 0;
      for (int t = 0; t < 24; t++) begin
         rho[px][py] = ((t+1)*(t+2)/2) % 16;
         nx = py;
         py = (2*px + 3*py) % 5;
         px = nx;
      end
      for (int x = 0; x < 5; x++)
         c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
      for (int x = 0; x < 5; x++)
         d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            b[y][(2*x+3*y)%5] = rotl(a[x][y] ^ d[x], rho[x][y]);
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            a[x][y] = b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y]);
      a[0][0] = a[0][0] ^ RC_TAB[r];
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            o[16*(x+5*y) +: 16] = a[x][y];
      return o;
   endfunction

   function automatic logic [399:0] permute(input logic [399:0] s);
      logic [399:0] t;
      t = s;
      for (int r = 0; r < 20; r++) t = model_round(t, r);
      return t;
   endfunction

   function automatic logic [399:0] rand400();
      logic [415:0] w;
      for (int i = 0; i < 13; i++) w[32*i +: 32] = $urandom;
      return w[399:0];
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Every cycle: a port-B write happens exactly when the model schedules one.
   always @(negedge clk) begin
      if (mon_on) begin
         bit e;
         e = exp_ctrl.exists(cyc);
         checks++;
         if (b_wr !== e) begin
            errors++;
            $display("FAIL wr_strobe cyc=%0d got=%b want=%b", cyc, b_wr, e);
         end else if (e) begin
            check("wr_ctrl", {392'h0, b_ctrl}, {392'h0, exp_ctrl[cyc]});
            check("wr_data", b_state, exp_data[cyc]);
         end
      end
   end

   // Called on a negedge with the block idle. Start edge is two edges later.
   task automatic run_op(input logic [399:0] st, input bit wr_state, input logic [7:0] start_byte,
                         input bit collide, output logic [399:0] res);
      int t0;
      logic [399:0] p;
      t0 = cyc + 2;
      p  = permute(st);
      exp_ctrl[t0]    = 8'h02;  exp_data[t0]    = st;
      exp_ctrl[t0+21] = 8'h04;  exp_data[t0+21] = p;
      if (collide) begin
         exp_ctrl[t0+23] = 8'h04;  exp_data[t0+23] = p;
      end
      a_state_wr = wr_state;  a_state = st;
      a_ctrl_wr  = 1'b1;      a_ctrl  = start_byte;
      @(negedge clk);
      a_state_wr = 1'b0;  a_ctrl_wr = 1'b0;
      wait_until(t0 + 21);
      check("busy_before_wb", {392'h0, mem_ctrl}, {392'h0, 8'h02});
      if (collide) begin
         a_ctrl_wr = 1'b1;  a_ctrl = 8'h00;
         @(negedge clk);
         a_ctrl_wr = 1'b0;
         check("collision_lost_done", {392'h0, mem_ctrl}, {392'h0, 8'h00});
         wait_until(t0 + 25);
      end else begin
         wait_until(t0 + 22);
      end
      check("done_ctrl", {392'h0, mem_ctrl}, {392'h0, 8'h04});
      check("result", mem_state, p);
      $display("op t0=%0d collide=%0d in_lane0=%h out_lane0=%h", t0, collide, st[15:0], mem_state[15:0]);
      res = p;
   endtask

   initial begin
      logic [399:0] s, st, res, res1;
      int t0;
      logic [7:0] pat [3];
      rstn = 1'b0;
      a_state_wr = 1'b0;  a_ctrl_wr = 1'b0;
      a_state = '0;       a_ctrl = 8'h00;

      // Hand-derived pins: one round of zero is RC[0]; second round row 0.
      s = model_round(400'h0, 0);
      check("pin_round0", s, 400'h1);
      s = model_round(s, 1);
      check("pin_round1_lane0", {384'h0, s[15:0]},  {384'h0, 16'h8083});
      check("pin_round1_lane2", {384'h0, s[47:32]}, {384'h0, 16'h8000});
      check("pin_round1_lane3", {384'h0, s[63:48]}, {384'h0, 16'h0001});
      check("pin_round1_lane4", {384'h0, s[79:64]}, {384'h0, 16'h9000});

      repeat (3) @(negedge clk);
      check("reset_wr",    {399'h0, b_wr}, 400'h0);
      check("reset_state", b_state, 400'h0);
      check("reset_ctrl",  {392'h0, b_ctrl}, 400'h0);
      rstn   = 1'b1;
      mon_on = 1'b1;

      run_op(400'h0, 1'b1, 8'h01, 1'b0, res);
      checks++;
      if (res[15:0] == 16'h0) begin
         errors++;
         $display("FAIL zero_lane0_nonzero got=%h want=nonzero", mem_state[15:0]);
      end

      for (int i = 0; i < 3; i++)
         run_op(rand400(), 1'b1, (i == 2) ? 8'hA9 : 8'h01, 1'b0, res);

      run_op(rand400(), 1'b1, 8'h01, 1'b1, res);

      // Abort during round 10: outputs clear, memory keeps busy and input.
      st = rand400();
      t0 = cyc + 2;
      exp_ctrl[t0] = 8'h02;  exp_data[t0] = st;
      a_state_wr = 1'b1;  a_state = st;  a_ctrl_wr = 1'b1;  a_ctrl = 8'h01;
      @(negedge clk);
      a_state_wr = 1'b0;  a_ctrl_wr = 1'b0;
      wait_until(t0 + 11);
      rstn = 1'b0;
      @(negedge clk);
      check("midrun_reset_wr",    {399'h0, b_wr}, 400'h0);
      check("midrun_reset_state", b_state, 400'h0);
      check("midrun_reset_ctrl",  {392'h0, b_ctrl}, 400'h0);
      rstn = 1'b1;
      check("midrun_mem_ctrl",  {392'h0, mem_ctrl}, {392'h0, 8'h02});
      check("midrun_mem_state", mem_state, st);
      $display("op t0=%0d aborted by reset in round 10", t0);
      repeat (25) @(negedge clk);

      // Back-to-back: first result stays in memory and feeds the second run.
      run_op(rand400(), 1'b1, 8'h01, 1'b0, res1);
      @(negedge clk);
      run_op(res1, 1'b0, 8'h01, 1'b0, res);
      check("back_to_back", mem_state, permute(res1));

      // Non-start control patterns must leave the engine idle and untouched.
      pat[0] = 8'h03;  pat[1] = 8'h00;  pat[2] = 8'h04;
      a_state_wr = 1'b1;  a_state = rand400();
      @(negedge clk);
      a_state_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_ctrl_wr = 1'b1;  a_ctrl = pat[i];
         @(negedge clk);
         a_ctrl_wr = 1'b0;
         repeat (17) @(negedge clk);
         check("nostart_state_held", b_state, res);
         check("nostart_ctrl_kept", {392'h0, mem_ctrl}, {392'h0, pat[i]});
         $display("idle pattern ctrl=%h held 18 cycles", pat[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
